ring_fifo: RTL and testbench
============================

# ring_fifo

Parametrised synchronous circular FIFO with oldest-word-at-head presentation, registered occupancy count, and full/empty plus programmable almost-full/almost-empty status. It is the general-purpose queue for datapaths in this codebase, placed between a producer that pushes and a consumer that pulls, in a single clock domain. Depth need not be a power of two. Concurrent push/pull at every occupancy, including full and empty, is fully defined.

## Interface
- DATA_WIDTH, 16, bits per stored word (≥1)
- DEPTH, 8, number of storage entries (≥2)
- AFULL_LEVEL, 6, almost_full asserts when count ≥ this (1..DEPTH)
- AEMPTY_LEVEL, 2, almost_empty asserts when count ≤ this (0..DEPTH-1)
- Derived: PTR_W = $clog2(DEPTH); CNT_W = $clog2(DEPTH+1)
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- push  in  1  write request; push_data is written when accepted
- push_data  in  DATA_WIDTH  word to enqueue
- pull  in  1  read request; pops the head when accepted
- head  out  DATA_WIDTH  oldest stored word; forced to 0 when empty
- count  out  CNT_W  number of stored words, 0..DEPTH
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count ≥ AFULL_LEVEL
- almost_empty  out  1  count ≤ AEMPTY_LEVEL
- overflow, underflow, err_clear: see Configuration

## Operation
- Storage: DEPTH × DATA_WIDTH register array; write pointer wr_ptr and read pointer rd_ptr of PTR_W bits; registered count of CNT_W bits. Full and empty are derived from count, never from pointer equality.
- push_acc = push & (!full | pull). A push while full is accepted only together with a pull.
- pull_acc = pull & !empty. A pull while empty is ignored, even when a push occurs in the same cycle.
- On push_acc: mem[wr_ptr] ← push_data; wr_ptr advances.
- On pull_acc: rd_ptr advances.
- Pointer wrap: when a pointer equals DEPTH-1 its next value is 0, otherwise +1. This holds for any DEPTH, not only powers of two.
- Count update:
  - push_acc only: +1
  - pull_acc only: −1
  - both: unchanged
  - neither: unchanged
- Full with push and pull: the head is popped and the new word is written into the freed slot. Count stays DEPTH.
- Empty with push and pull: only the push takes effect. Count becomes 1.
- A rejected push (full, no pull) leaves memory, pointers and count untouched.
- head = empty ? 0 : mem[rd_ptr], combinational from registered state.
- full, empty, almost_full and almost_empty are combinational compares of count.
- Reset: wr_ptr = rd_ptr = 0, count = 0. Outputs become head 0, full 0, empty 1, almost_full 0, almost_empty 1, overflow 0, underflow 0. Memory contents are not cleared.
- Reset mid-operation takes priority over push and pull in the same cycle. All stored data is discarded.

## Timing
- All state changes on the rising edge of clock; no combinational path from push or pull to any output.
- Write-to-head latency: a word pushed into an empty FIFO at edge N appears on head, with empty=0, after edge N.
- Pull latency: pull sampled at edge N; the next word is on head after edge N.
- Status outputs reflect the count after the current edge, with no extra cycle of delay.
- Sustained throughput: one push and one pull every cycle at any occupancy from 1 to DEPTH.

## Configuration
- Macro: RING_FIFO_ERR_FLAGS_EN.
- Defined:
  - Adds input err_clear (1 bit) and outputs overflow and underflow (1 bit each), all registered.
  - overflow sets on the edge after a rejected push (push & full & !pull). underflow sets on the edge after a rejected pull (pull & empty).
  - Both flags are sticky until reset or err_clear. If err_clear and a new error occur in the same cycle, the set wins.
- Undefined: these ports do not exist; rejected requests are silently dropped. Queue behaviour is otherwise identical.

## Test plan
All scenarios use DATA_WIDTH=16, DEPTH=8, AFULL_LEVEL=6, AEMPTY_LEVEL=2.
- Reset then idle -> count=0, empty=1, almost_empty=1, full=0, head=0x0000.
- Push 0x0001..0x0008 on consecutive cycles -> count 1..8; almost_empty drops at count 3; almost_full rises at count 6; full=1 at 8; head=0x0001 throughout.
- While full, push 0x00AA without pull -> count stays 8, head stays 0x0001, overflow=1 (macro on). Then push 0x00BB with pull -> head=0x0002, count=8, and 0x00BB is the last word drained.
- From empty, push and pull simultaneously with 0x1234 -> count=1, head=0x1234, underflow=1 (macro on). err_clear for one cycle -> underflow=0.
- Wrap: 20 cycles of push+pull at count=3 with incrementing data -> head sequence in order with no gaps across the 7→0 pointer wrap.
- Assert reset at count=5 while push=1 -> next cycle count=0, empty=1, head=0; the pushed word is not stored.

Source files
------------

// File: rtl/ring_fifo.sv
// ring_fifo: parametrised single-clock circular FIFO.
//
// Oldest word is presented on head (forced to 0 when empty). Occupancy is a
// registered count; full/empty/almost flags are compares of that count, so
// DEPTH need not be a power of two and pointer equality is never used.
// Concurrent push and pull are defined at every occupancy: at full the head is
// popped and the new word lands in the freed slot; at empty only the push acts.
//
// Optional feature macro: RING_FIFO_ERR_FLAGS_EN
//   adds err_clear input and sticky overflow/underflow outputs.
//
// Ports:
//   clock        rising-edge clock
//   reset        synchronous, active-high; clears pointers, count, flags
//   push         write request (accepted when !full or together with pull)
//   push_data    word to enqueue
//   pull         read request (ignored when empty)
//   head         oldest stored word, 0 when empty
//   count        stored words, 0..DEPTH
//   full/empty   count == DEPTH / count == 0
//   almost_full  count >= AFULL_LEVEL
//   almost_empty count <= AEMPTY_LEVEL
//   err_clear, overflow, underflow  (only with RING_FIFO_ERR_FLAGS_EN)
module ring_fifo #(
  parameter int DATA_WIDTH   = 16,
  parameter int DEPTH        = 8,
  parameter int AFULL_LEVEL  = 6,
  parameter int AEMPTY_LEVEL = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pull,
`ifdef RING_FIFO_ERR_FLAGS_EN
  input  logic                  err_clear,
  output logic                  overflow,
  output logic                  underflow,
`endif
  output logic [DATA_WIDTH-1:0] head,
  output logic [CNT_W-1:0]      count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty
);

  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AFULL_C  = CNT_W'(AFULL_LEVEL);
  localparam logic [CNT_W-1:0] AEMPTY_C = CNT_W'(AEMPTY_LEVEL);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic                  push_acc, pull_acc;

  // Explicit wrap at DEPTH-1 so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign full         = (count == DEPTH_C);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AFULL_C);
  assign almost_empty = (count <= AEMPTY_C);

  // A push at full is only taken when the pull frees a slot in the same cycle.
  assign push_acc = push & (~full | pull);
  assign pull_acc = pull & ~empty;

  assign head = empty ? '0 : mem[rd_ptr];

  // Storage is deliberately not reset; count gates visibility of stale data.
  always_ff @(posedge clock) begin
    if (!reset && push_acc) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_acc) wr_ptr <= ptr_inc(wr_ptr);
      if (pull_acc) rd_ptr <= ptr_inc(rd_ptr);
      case ({push_acc, pull_acc})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef RING_FIFO_ERR_FLAGS_EN
  // Sticky error flags; a new error in the same cycle beats err_clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push & full & ~pull) overflow <= 1'b1;
      else if (err_clear)      overflow <= 1'b0;
      if (pull & empty)        underflow <= 1'b1;
      else if (err_clear)      underflow <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_ring_fifo.sv
// Scoreboard bench for ring_fifo: the driver updates a queue-based reference
// model at each edge and pushes the expected post-edge outputs; a monitor on
// the falling edge pops and compares against the DUT.
module tb_ring_fifo;
  localparam int DW = 16, D = 8, AF = 6, AE = 2;
  localparam int CW = $clog2(D + 1);

  logic          clock = 1'b0;
  logic          reset = 1'b0, push = 1'b0, pull = 1'b0;
  logic [DW-1:0] push_data = '0;
  logic [DW-1:0] head;
  logic [CW-1:0] count;
  logic          full, empty, almost_full, almost_empty;
`ifdef RING_FIFO_ERR_FLAGS_EN
  logic          err_clear = 1'b0;
  logic          overflow, underflow;
`endif

  ring_fifo #(.DATA_WIDTH(DW), .DEPTH(D), .AFULL_LEVEL(AF), .AEMPTY_LEVEL(AE)) dut (
    .clock(clock), .reset(reset), .push(push), .push_data(push_data), .pull(pull),
`ifdef RING_FIFO_ERR_FLAGS_EN
    .err_clear(err_clear), .overflow(overflow), .underflow(underflow),
`endif
    .head(head), .count(count), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [DW-1:0] head;
    int            count;
    bit            full, empty, af, ae, ovf, unf;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] mq[$];
  bit            m_ovf = 1'b0, m_unf = 1'b0;
  int            vectors = 0, miscompares = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  // One clock of stimulus; model applies the queue rules at the edge.
  task automatic step(input bit r, input bit p, input logic [DW-1:0] d,
                      input bit l, input bit c);
    exp_t e;
    int   n;
    @(negedge clock);
    #1;
    reset = r; push = p; push_data = d; pull = l;
`ifdef RING_FIFO_ERR_FLAGS_EN
    err_clear = c;
`endif
    @(posedge clock);
    n = mq.size();
    if (r) begin
      mq.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      if (p && n == D && !l) m_ovf = 1'b1; else if (c) m_ovf = 1'b0;
      if (l && n == 0)       m_unf = 1'b1; else if (c) m_unf = 1'b0;
      if (l && n > 0) void'(mq.pop_front());
      if (p && (n < D || l)) mq.push_back(d);
    end
    e.count = mq.size();
    e.head  = (mq.size() > 0) ? mq[0] : '0;
    e.full  = (e.count == D);
    e.empty = (e.count == 0);
    e.af    = (e.count >= AF);
    e.ae    = (e.count <= AE);
    e.ovf   = m_ovf;
    e.unf   = m_unf;
    exp_q.push_back(e);
  endtask

  exp_t mon_e;
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("head",         32'(head),         32'(mon_e.head));
      chk("count",        32'(count),        32'(mon_e.count));
      chk("full",         32'(full),         32'(mon_e.full));
      chk("empty",        32'(empty),        32'(mon_e.empty));
      chk("almost_full",  32'(almost_full),  32'(mon_e.af));
      chk("almost_empty", 32'(almost_empty), 32'(mon_e.ae));
`ifdef RING_FIFO_ERR_FLAGS_EN
      chk("overflow",     32'(overflow),     32'(mon_e.ovf));
      chk("underflow",    32'(underflow),    32'(mon_e.unf));
`endif
    end
  end

  initial begin
    int mode;
    // reset then idle
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    // fill 1..8
    for (int i = 1; i <= 8; i++) step(0, 1, DW'(i), 0, 0);
    // rejected push at full, then push with pull at full
    step(0, 1, 16'h00AA, 0, 0);
    step(0, 1, 16'h00BB, 1, 0);
    repeat (9) step(0, 0, 0, 1, 0);          // drain, last one underflows
    // empty with push+pull: only push acts
    step(0, 1, 16'h1234, 1, 0);
    step(0, 0, 0, 0, 1);                     // err_clear
    step(0, 0, 0, 1, 0);
    // wrap at count 3
    for (int i = 0; i < 3; i++) step(0, 1, DW'(16'h0100 + i), 0, 0);
    for (int i = 3; i < 23; i++) step(0, 1, DW'(16'h0100 + i), 1, 0);
    // reset at count 5 with push active
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, DW'(16'h0200 + i), 0, 0);
    step(1, 1, 16'hDEAD, 0, 0);
    step(0, 0, 0, 0, 0);
    // randomized traffic with occupancy-biasing phases
    mode = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 40 == 0) mode = $urandom_range(0, 2);
      step($urandom_range(0, 199) == 0,
           (mode == 0) ? ($urandom_range(0, 3) != 0) : (mode == 1) ? ($urandom_range(0, 3) == 0) : $urandom_range(0, 1) == 1,
           DW'($urandom),
           (mode == 1) ? ($urandom_range(0, 3) != 0) : (mode == 0) ? ($urandom_range(0, 3) == 0) : $urandom_range(0, 1) == 1,
           $urandom_range(0, 15) == 0);
    end
    // bounded wait for the monitor to consume everything
    for (int k = 0; k < 4 && exp_q.size() > 0; k++) @(negedge clock);
    #2;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected entries left unchecked, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
